// File: rtl/fifo_param_pkg.sv
// Shared types and helpers for the parametrised FIFO slice.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned use_dw_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bundle of the FIFO: control, data and status.
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) ();

  localparam int unsigned CW = use_dw_w(DEPTH);

  logic              CLEAR_N;
  logic              WRITE;
  logic              READ;
  logic [DATA_W-1:0] DATA_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic              F_FULL_N;
  logic              F_EMPTY_N;
  logic              F_AFULL_N;
  logic              F_AEMPTY_N;
  logic [CW-1:0]     USE_DW;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output CLEAR_N, WRITE, READ, DATA_IN,
    input  DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
    input  USE_DW, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CLEAR_N, WRITE, READ, DATA_IN,
    output DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
    output USE_DW, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/fifo_param_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// A read and write to the same address on one edge returns the old word.
module ram_dp #(
  parameter int unsigned mem_depth = 32,
  parameter int unsigned size      = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(mem_depth)-1:0] waddr,
  input  logic [size-1:0]              wdata,
  input  logic                         re,
  input  logic [$clog2(mem_depth)-1:0] raddr,
  output logic [size-1:0]              rdata
);

  logic [size-1:0] mem [mem_depth];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags and control FSM
// around a ram_dp. Define FIFO_SHOWAHEAD_EN for first-word-fall-through.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AFULL_TH  = DEPTH - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input logic         CLOCK,
  input logic         RESET_N,
  fifo_param_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = use_dw_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_TH);

  fifo_state_t       state, state_nxt;
  logic [AW-1:0]     waddr, raddr, waddr_nxt, raddr_nxt, ram_ra;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              clr, rd_acc, wr_acc, ovf_set, udf_set, ram_we, ram_re;
  logic              full_n, empty_n, afull_n, aempty_n, ovf, udf;
  logic [DATA_W-1:0] ram_q, dout;
`ifdef FIFO_SHOWAHEAD_EN
  logic              collide, pf_valid, pf_fwd;
  logic [DATA_W-1:0] fwd_data;
`else
  logic              rd_pend;
`endif

  // Accept decisions, next pointers and next occupancy.
  always_comb begin
    clr       = !bus.CLEAR_N;
    rd_acc    = bus.READ && (state != ST_EMPTY);
    wr_acc    = bus.WRITE && ((state != ST_FULL) || rd_acc);
    ovf_set   = bus.WRITE && !wr_acc;
    udf_set   = bus.READ && !rd_acc;
    waddr_nxt = wr_acc ? waddr + 1'b1 : waddr;
    raddr_nxt = rd_acc ? raddr + 1'b1 : raddr;
    cnt_nxt   = cnt;
    if (wr_acc && !rd_acc)      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt - 1'b1;
  end

  // FSM next-state, kept in step with the occupancy count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY:   if (wr_acc) state_nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (wr_acc && !rd_acc && cnt == CNT_LAST)     state_nxt = ST_FULL;
        else if (rd_acc && !wr_acc && cnt == CNT_ONE) state_nxt = ST_EMPTY;
      end
      ST_FULL:    if (rd_acc && !wr_acc) state_nxt = ST_PARTIAL;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  // RAM port control; show-ahead keeps the head prefetched at the next read pointer.
  always_comb begin
    ram_we = wr_acc && !clr;
`ifdef FIFO_SHOWAHEAD_EN
    ram_re  = (cnt_nxt != '0) && !clr;
    ram_ra  = raddr_nxt;
    // Head location is being written this edge, so the RAM returns a stale word.
    collide = wr_acc && (waddr == raddr_nxt);
`else
    ram_re = rd_acc && !clr;
    ram_ra = raddr;
`endif
  end

  ram_dp #(
    .mem_depth (DEPTH),
    .size      (DATA_W)
  ) u_ram (
    .clk   (CLOCK),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (bus.DATA_IN),
    .re    (ram_re),
    .raddr (ram_ra),
    .rdata (ram_q)
  );

  // FSM state register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)  state <= ST_EMPTY;
    else if (clr)  state <= ST_EMPTY;
    else           state <= state_nxt;
  end

  // Pointers, count, registered flags, sticky errors and output data.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N || clr) begin
      waddr    <= '0;
      raddr    <= '0;
      cnt      <= '0;
      full_n   <= 1'b1;
      empty_n  <= 1'b0;
      afull_n  <= 1'b1;
      aempty_n <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      dout     <= '0;
`ifdef FIFO_SHOWAHEAD_EN
      pf_valid <= 1'b0;
      pf_fwd   <= 1'b0;
      fwd_data <= '0;
`else
      rd_pend  <= 1'b0;
`endif
    end else begin
      waddr    <= waddr_nxt;
      raddr    <= raddr_nxt;
      cnt      <= cnt_nxt;
      full_n   <= (cnt_nxt != CNT_FULL);
      empty_n  <= (cnt_nxt != '0);
      afull_n  <= (cnt_nxt < CNT_AF);
      aempty_n <= (cnt_nxt > CNT_AE);
      ovf      <= ovf | ovf_set;
      udf      <= udf | udf_set;
`ifdef FIFO_SHOWAHEAD_EN
      pf_valid <= (cnt_nxt != '0) && !collide;
      // Forward the written word only once the FIFO already holds data.
      pf_fwd   <= (cnt_nxt != '0) && collide && (state != ST_EMPTY);
      fwd_data <= bus.DATA_IN;
      if (cnt_nxt == '0) dout <= '0;
      else if (pf_valid) dout <= ram_q;
      else if (pf_fwd)   dout <= fwd_data;
`else
      rd_pend  <= rd_acc;
      if (rd_pend) dout <= ram_q;
`endif
    end
  end

  assign bus.DATA_OUT   = dout;
  assign bus.F_FULL_N   = full_n;
  assign bus.F_EMPTY_N  = empty_n;
  assign bus.F_AFULL_N  = afull_n;
  assign bus.F_AEMPTY_N = aempty_n;
  assign bus.USE_DW     = cnt;
  assign bus.OVERFLOW   = ovf;
  assign bus.UNDERFLOW  = udf;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=32, DATA_W=8) with a queue model and
// an output scoreboard keyed on the cycle each read result is due.
module tb_fifo_param;

  localparam int unsigned DEPTH = 32;

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [7:0] mq[$];
  sb_t        sb[$];
  logic       movf, mudf;
  logic [7:0] mdout;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  fifo_param #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .AFULL_TH  (DEPTH - 4),
    .AEMPTY_TH (4)
  ) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    movf  = 1'b0;
    mudf  = 1'b0;
    mdout = '0;
  endtask

  task automatic check_all();
    sb_t e;
    chk("use_dw",   32'(bus.USE_DW), mq.size());
    chk("full_n",   32'(bus.F_FULL_N), 32'(mq.size() != DEPTH));
    chk("empty_n",  32'(bus.F_EMPTY_N), 32'(mq.size() != 0));
    chk("afull_n",  32'(bus.F_AFULL_N), 32'(!(mq.size() >= DEPTH - 4)));
    chk("aempty_n", 32'(bus.F_AEMPTY_N), 32'(!(mq.size() <= 4)));
    chk("overflow", 32'(bus.OVERFLOW), 32'(movf));
    chk("underflow", 32'(bus.UNDERFLOW), 32'(mudf));
`ifndef FIFO_SHOWAHEAD_EN
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      mdout = e.data;
    end
    chk("data_out", 32'(bus.DATA_OUT), 32'(mdout));
`endif
  endtask

  // One clock: drive inputs, update the model at the edge, check after it.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic cn);
    logic rd_ok, wr_ok;
    logic [7:0] hd;
    bus.WRITE   = w;
    bus.READ    = r;
    bus.DATA_IN = d;
    bus.CLEAR_N = cn;
    @(posedge clk);
    cyc++;
    if (!cn) begin
      model_reset();
    end else begin
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (r && !rd_ok) mudf = 1'b1;
      if (w && !wr_ok) movf = 1'b1;
      if (rd_ok) begin
        hd = mq.pop_front();
`ifndef FIFO_SHOWAHEAD_EN
        sb.push_back('{data: hd, due: cyc + 1});
`endif
      end
      if (wr_ok) mq.push_back(d);
    end
    #1;
    bus.WRITE   = 1'b0;
    bus.READ    = 1'b0;
    bus.CLEAR_N = 1'b1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.CLEAR_N = 1'b1;
    bus.WRITE   = 1'b0;
    bus.READ    = 1'b0;
    bus.DATA_IN = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Fill to full; almost-full from 28 is covered per step.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
    // Write while full is rejected and sets OVERFLOW.
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    // Drain: data 0x00..0x1F in order, 0xAA never appears.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sb_drain1", sb.size(), 0);

    // Empty with read+write: write accepted, UNDERFLOW set.
    step(1'b1, 1'b1, 8'h55, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Full with read+write for 40 cycles across pointer wrap.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'(i * 7 + 3), 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sb_drain2", sb.size(), 0);

    // Partial with read+write and random mix.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);

    // Clear while a read is in flight and another is requested.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("clr_data_out", 32'(bus.DATA_OUT), 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_data_out_hold", 32'(bus.DATA_OUT), 0);
    step(1'b1, 1'b0, 8'h99, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef FIFO_SHOWAHEAD_EN
    // First-word-fall-through: word visible two edges after the write.
    step(1'b1, 1'b0, 8'h3C, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft_head", 32'(bus.DATA_OUT), 32'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("fwft_empty_data", 32'(bus.DATA_OUT), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO, successor to the fixed 8-bit x 32 FIFO.
- Adds generic data width and depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a defined simultaneous read/write policy in every state.
- Storage is the team's dual-port RAM; this block owns the pointers, the occupancy count, the flags and the control FSM.
- Sits between producer and consumer logic in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 32, number of words; must be a power of two, at least 4.
- AFULL_TH, DEPTH-4, F_AFULL_N goes low when USE_DW >= AFULL_TH.
- AEMPTY_TH, 4, F_AEMPTY_N goes low when USE_DW <= AEMPTY_TH.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CLEAR_N  in  1  synchronous active-low clear; takes priority over READ and WRITE.
- WRITE  in  1  write request.
- READ  in  1  read request.
- DATA_IN  in  DATA_W  write data.
- DATA_OUT  out  DATA_W  read data.
- F_FULL_N  out  1  low when full.
- F_EMPTY_N  out  1  low when empty.
- F_AFULL_N  out  1  low when almost full.
- F_AEMPTY_N  out  1  low when almost empty.
- USE_DW  out  $clog2(DEPTH)+1  occupancy, range 0..DEPTH.
- OVERFLOW  out  1  sticky; set by a write rejected while full.
- UNDERFLOW  out  1  sticky; set by a read rejected while empty.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - waddr, raddr, USE_DW = 0; DATA_OUT = 0; OVERFLOW = UNDERFLOW = 0.
  - F_EMPTY_N = 0, F_AEMPTY_N = 0, F_FULL_N = 1, F_AFULL_N = 1; FSM goes to ST_EMPTY.
- CLEAR_N low at a clock edge: same register values as reset, applied synchronously. RAM contents are not cleared. A reset or clear in mid-operation drops any in-flight read; DATA_OUT returns to 0.
- FSM states ST_EMPTY, ST_PARTIAL, ST_FULL, always consistent with USE_DW:
  - ST_EMPTY -> ST_PARTIAL on an accepted write.
  - ST_PARTIAL -> ST_FULL on a write-only when USE_DW == DEPTH-1.
  - ST_PARTIAL -> ST_EMPTY on a read-only when USE_DW == 1.
  - ST_FULL -> ST_PARTIAL on an accepted read-only.
  - All other cases hold the current state.
- Accept rules:
  - Write accepted iff WRITE and (not full, or READ accepted in the same cycle while full).
  - Read accepted iff READ and not empty.
  - Empty with READ and WRITE together: write accepted, read rejected, UNDERFLOW set.
  - Full with READ and WRITE together: both accepted, USE_DW unchanged.
  - Partial with READ and WRITE together: both accepted, USE_DW unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- USE_DW: +1 on write-only, -1 on read-only, unchanged otherwise; it never exceeds DEPTH or goes below 0.
- Flags are registered and updated in the same edge as USE_DW: F_EMPTY_N low iff USE_DW == 0; F_FULL_N low iff USE_DW == DEPTH.
- Read latency is 1 cycle: an accepted read at edge N presents the head word on DATA_OUT after edge N+1. DATA_OUT holds its last value when no read is accepted.
- OVERFLOW and UNDERFLOW are cleared only by reset or clear. A rejected access never changes pointers, count or RAM.

Optional Feature:
- FIFO_SHOWAHEAD_EN defined: first-word-fall-through.
  - DATA_OUT shows the head word while not empty, with no READ needed.
  - READ pops the word and the next head appears after the following edge.
  - DATA_OUT = 0 while empty.
  - A word written into an empty FIFO appears on DATA_OUT 2 cycles after the write edge.
- Not defined: normal mode with 1-cycle read latency, as described above.

Decomposition:
- Package fifo_pkg:
  - typedef enum fifo_state_t {ST_EMPTY, ST_PARTIAL, ST_FULL}.
  - Localparam helper function for the USE_DW width.
- Sub-module: ram_dp, instantiated with mem_depth = DEPTH and size = DATA_W. Its write enable is the accepted write; its read enable is the accepted read, or the head prefetch in show-ahead mode.
- Pointers, count, flags and FSM stay in fifo_param.

Test Plan:
- Reset, then 32 writes 0x00..0x1F (DEPTH=32) -> USE_DW=32, F_FULL_N=0, F_AFULL_N=0 from USE_DW=28, OVERFLOW=0.
- Full, one more write 0xAA -> rejected, OVERFLOW=1, USE_DW=32; the following 32 reads return 0x00..0x1F in order, with no 0xAA.
- Empty, READ and WRITE together with 0x55 -> USE_DW=1, UNDERFLOW=1; the next read returns 0x55 one cycle later.
- Full, READ and WRITE together for 40 cycles -> USE_DW stays 32, F_FULL_N stays 0, data order preserved across pointer wrap.
- 10 words stored, CLEAR_N low for one edge during a READ -> USE_DW=0, F_EMPTY_N=0, DATA_OUT=0, error flags 0; a new write then read returns the new word.
- With FIFO_SHOWAHEAD_EN, write 0x3C into empty -> DATA_OUT=0x3C two cycles after the write edge with no READ; READ -> F_EMPTY_N=0 next cycle.
